// File: rtl/regfile_param.sv
`default_nettype none
// ==========================================================================
// regfile_param: DATA_W x DEPTH register file with two forwarding read ports,
// a debug read port and a one-entry-per-cycle clear sequencer. Revision 1.0
// ==========================================================================
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdata,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] number
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              rs_zero, rt_zero, idx_zero;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // clear_req is only looked at in IDLE, so a request mid-clear cannot restart it
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == LAST_PTR) state_nxt = IDLE;
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_ok = !busy && regwrite && in_range(writeaddr)
                 && !(ZERO_REG && (writeaddr == '0));

  // One shared write port keeps the array mappable to distributed RAM
  assign mem_we = busy || wr_ok;
  assign mem_wa = busy ? ptr : writeaddr;
  assign mem_wd = busy ? '0  : writedata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rs_zero  = busy || !in_range(rs)    || (ZERO_REG && (rs    == '0));
  assign rt_zero  = busy || !in_range(rt)    || (ZERO_REG && (rt    == '0));
  assign idx_zero = busy || !in_range(index) || (ZERO_REG && (index == '0));

  assign rsdata = rs_zero  ? '0 : (wr_ok && (writeaddr == rs)) ? writedata : mem[rs];
  assign rtdata = rt_zero  ? '0 : (wr_ok && (writeaddr == rt)) ? writedata : mem[rt];
  assign number = idx_zero ? '0 : mem[index];

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ==========================================================================
// tb_regfile_param: scoreboard bench for regfile_param (default, ZERO_REG=0,
// and 16x12 configurations). Revision 1.0
// ==========================================================================
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;

  // Shared stimulus for the two 32x32 instances
  logic        clear_req = 1'b0;
  logic        regwrite  = 1'b0;
  logic [4:0]  writeaddr = '0;
  logic [31:0] writedata = '0;
  logic [4:0]  rs = '0, rt = '0, index = '0;
  logic        busy_a, busy_b;
  logic [31:0] rsdata_a, rtdata_a, number_a;
  logic [31:0] rsdata_b, rtdata_b, number_b;

  // Stimulus for the 16-bit x 12-entry instance
  logic        c_clear_req = 1'b0;
  logic        c_regwrite  = 1'b0;
  logic [3:0]  c_writeaddr = '0;
  logic [15:0] c_writedata = '0;
  logic [3:0]  c_rs = '0, c_rt = '0, c_index = '0;
  logic        busy_c;
  logic [15:0] rsdata_c, rtdata_c, number_c;

  regfile_param dut_a (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_a),
    .rs(rs), .rt(rt), .rsdata(rsdata_a), .rtdata(rtdata_a),
    .regwrite(regwrite), .writeaddr(writeaddr), .writedata(writedata),
    .index(index), .number(number_a)
  );

  regfile_param #(.ZERO_REG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_b),
    .rs(rs), .rt(rt), .rsdata(rsdata_b), .rtdata(rtdata_b),
    .regwrite(regwrite), .writeaddr(writeaddr), .writedata(writedata),
    .index(index), .number(number_b)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear_req(c_clear_req), .busy(busy_c),
    .rs(c_rs), .rt(c_rt), .rsdata(rsdata_c), .rtdata(rtdata_c),
    .regwrite(c_regwrite), .writeaddr(c_writeaddr), .writedata(c_writedata),
    .index(c_index), .number(number_c)
  );

  localparam int S_BUSY_A = 0, S_RS_A = 1, S_RT_A = 2, S_NUM_A = 3, S_RS_B = 4,
                 S_BUSY_C = 5, S_RS_C = 6, S_RT_C = 7, S_NUM_C = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  idx;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_num;
    logic [31:0] e_rsb;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      S_BUSY_A: return {31'b0, busy_a};
      S_RS_A:   return rsdata_a;
      S_RT_A:   return rtdata_a;
      S_NUM_A:  return number_a;
      S_RS_B:   return rsdata_b;
      S_BUSY_C: return {31'b0, busy_c};
      S_RS_C:   return {16'b0, rsdata_c};
      S_RT_C:   return {16'b0, rtdata_c};
      S_NUM_C:  return {16'b0, number_c};
      default:  return 'x;
    endcase
  endfunction

  task automatic push_exp(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = get_out(e.sel);
      n_cmp++;
      if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.val, $time);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Forwarding, readback and zero-register vectors (dut_b has ZERO_REG=0)
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd9, 32'h12345678, 5'd9, 5'd5, 5'd9, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 5'd9, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd9, 5'd0, 32'h0,        32'h12345678, 32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1'b1, 5'd5, 32'h0A0A0A0A, 5'd5, 5'd5, 5'd5, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'hDEADBEEF, 32'h0A0A0A0A};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 5'd5, 32'h0A0A0A0A, 32'h0,        32'h0A0A0A0A, 32'h0A0A0A0A};

    rs   = 5'd7;
    c_rs = 4'd7;
    tick();
    tick();

    // Asynchronous reset assertion mid-cycle
    #2 rst_n = 1'b0;
    #1;
    push_exp("async_busy_a", S_BUSY_A, 32'd1);
    push_exp("async_busy_c", S_BUSY_C, 32'd1);
    push_exp("async_rs_a",   S_RS_A,   32'd0);
    push_exp("async_num_a",  S_NUM_A,  32'd0);
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;

    for (int k = 1; k <= 32; k++) begin
      tick();
      push_exp("rst_busy_a", S_BUSY_A, (k < 32) ? 32'd1 : 32'd0);
      push_exp("rst_busy_c", S_BUSY_C, (k < 12) ? 32'd1 : 32'd0);
      push_exp("rst_rs7_a",  S_RS_A,   32'd0);
      push_exp("rst_rs7_c",  S_RS_C,   32'd0);
      sample();
    end
    tick();

    for (int i = 0; i < 8; i++) begin
      regwrite  = vecs[i].we;
      writeaddr = vecs[i].wa;
      writedata = vecs[i].wd;
      rs        = vecs[i].rs;
      rt        = vecs[i].rt;
      index     = vecs[i].idx;
      push_exp($sformatf("vec%0d_rs",  i), S_RS_A,  vecs[i].e_rs);
      push_exp($sformatf("vec%0d_rt",  i), S_RT_A,  vecs[i].e_rt);
      push_exp($sformatf("vec%0d_num", i), S_NUM_A, vecs[i].e_num);
      push_exp($sformatf("vec%0d_rsb", i), S_RS_B,  vecs[i].e_rsb);
      sample();
      tick();
    end
    regwrite = 1'b0;

    // Fill r1..r31 with their own index, then clear mid-use
    for (int i = 1; i < 32; i++) begin
      regwrite  = 1'b1;
      writeaddr = 5'(i);
      writedata = 32'(i);
      tick();
    end
    regwrite = 1'b0;
    rs = 5'd31; rt = 5'd1; index = 5'd17;
    push_exp("fill_rs31", S_RS_A,  32'd31);
    push_exp("fill_rt1",  S_RT_A,  32'd1);
    push_exp("fill_num17", S_NUM_A, 32'd17);
    sample();
    tick();

    clear_req = 1'b1; regwrite = 1'b1; writeaddr = 5'd2; writedata = 32'h55; rs = 5'd2;
    push_exp("clr_edge_busy", S_BUSY_A, 32'd0);
    push_exp("clr_edge_fwd",  S_RS_A,   32'h55);
    sample();
    for (int k = 1; k <= 33; k++) begin
      tick();
      clear_req = (k == 10);
      regwrite  = (k <= 32);
      writeaddr = 5'd3;
      writedata = 32'hBAD;
      rs        = 5'd3;
      push_exp("clr_busy_a", S_BUSY_A, (k <= 32) ? 32'd1 : 32'd0);
      push_exp("clr_rs3",    S_RS_A,   32'd0);
      sample();
    end
    clear_req = 1'b0;
    regwrite  = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i); index = 5'(i);
      push_exp($sformatf("post_clr_rs%0d",  i), S_RS_A,  32'd0);
      push_exp($sformatf("post_clr_rt%0d",  i), S_RT_A,  32'd0);
      push_exp($sformatf("post_clr_num%0d", i), S_NUM_A, 32'd0);
      push_exp($sformatf("post_clr_rsb%0d", i), S_RS_B,  32'd0);
      sample();
    end
    tick();

    // 16-bit x 12-entry instance: in-range write, out-of-range write, clear length
    c_regwrite = 1'b1; c_writeaddr = 4'd11; c_writedata = 16'hBEEF; c_rs = 4'd11; c_index = 4'd11;
    push_exp("c_fwd_r11",     S_RS_C,  32'hBEEF);
    push_exp("c_num_r11_old", S_NUM_C, 32'h0);
    sample();
    tick();
    c_regwrite = 1'b0; c_rt = 4'd11;
    push_exp("c_rs_r11",  S_RS_C,  32'hBEEF);
    push_exp("c_rt_r11",  S_RT_C,  32'hBEEF);
    push_exp("c_num_r11", S_NUM_C, 32'hBEEF);
    sample();
    tick();
    c_regwrite = 1'b1; c_writeaddr = 4'd13; c_writedata = 16'h1234; c_rs = 4'd13;
    push_exp("c_fwd_r13", S_RS_C, 32'h0);
    push_exp("c_rt_keep", S_RT_C, 32'hBEEF);
    sample();
    tick();
    c_regwrite = 1'b0; c_index = 4'd13;
    push_exp("c_rs_r13",  S_RS_C,  32'h0);
    push_exp("c_num_r13", S_NUM_C, 32'h0);
    sample();
    tick();

    c_clear_req = 1'b1;
    tick();
    c_clear_req = 1'b0;
    c_rs = 4'd11;
    for (int k = 1; k <= 13; k++) begin
      push_exp("c_clr_busy", S_BUSY_C, (k <= 12) ? 32'd1 : 32'd0);
      sample();
      tick();
    end
    push_exp("c_post_clr_r11", S_RS_C, 32'h0);
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the CPU register file: DATA_W x DEPTH storage, two combinational read ports (rs/rt), one synchronous write port, and one debug read port (index/number) for the board display.
- Adds three things the previous generation lacked:
  - Async active-low reset.
  - A hardware clear sequencer that zeroes the array one entry per cycle, so the array can still map to LUTRAM.
  - Write-to-read forwarding, replacing the half-cycle write/read trick.
- Sits in the decode stage between the instruction decoder and the ALU operand muxes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width.
- DEPTH, 2**ADDR_W, number of registers. Must satisfy 2 <= DEPTH <= 2**ADDR_W.
- ZERO_REG, 1, when 1, address 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  single-cycle request to re-zero the whole array.
- busy  out  1  high while the clear sequence runs; the pipeline stalls on it.
- rs  in  ADDR_W  read port A address.
- rt  in  ADDR_W  read port B address.
- rsdata  out  DATA_W  read port A data.
- rtdata  out  DATA_W  read port B data.
- regwrite  in  1  write enable.
- writeaddr  in  ADDR_W  write address.
- writedata  in  DATA_W  write data.
- index  in  ADDR_W  debug read address.
- number  out  DATA_W  debug read data.

Behaviour:
- Reset and clock: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- On rst_n=0:
  - FSM goes to CLEAR immediately; ptr=0; busy=1.
  - rsdata, rtdata and number read 0.
  - Array contents are not reset directly.
- FSM states: IDLE, CLEAR.
  - IDLE: clear_req=1 at a rising edge -> CLEAR, ptr=0, busy=1 from the next cycle.
  - CLEAR: each edge writes 0 to entry ptr, then ptr++. The edge that writes ptr==DEPTH-1 -> IDLE, busy=0.
  - Clear length is exactly DEPTH cycles after rst_n deasserts, or after the clear_req edge.
  - clear_req while already in CLEAR is ignored; the sequence does not restart.
  - rst_n asserted mid-clear restarts at ptr=0.
- While busy=1:
  - regwrite is dropped; no array write occurs.
  - rsdata, rtdata and number are forced to 0.
- Write, when IDLE and regwrite=1: array[writeaddr] <= writedata on the rising edge.
  - Dropped if ZERO_REG=1 and writeaddr=0.
  - Dropped if writeaddr >= DEPTH.
- Read, combinational, IDLE:
  - rsdata = 0 if (ZERO_REG && rs==0) or rs >= DEPTH.
  - Otherwise, forwarding: if regwrite && writeaddr==rs and the write is not dropped, rsdata = writedata.
  - Otherwise rsdata = array[rs].
  - rtdata uses the same rules with rt.
  - Zero-read latency; a same-cycle write is visible on the read port in that cycle.
- Debug port: number uses the same rules as rsdata but has no forwarding; it reflects array[index] only after the write edge.
- Simultaneous clear_req and regwrite in IDLE: the write commits on that edge, then the clear starts. The result is all-zero after the clear.
- No X on any output after reset; the array is always cleared before first use.

Test Plan:
- Reset: pulse rst_n low mid-cycle, release.
  - busy=1 asynchronously.
  - busy stays 1 for exactly 32 edges, then 0.
  - rs=7 reads 0 throughout and after.
- Write/readback: write 0xDEADBEEF to r5, then rs=5 and rt=5 on the next cycle -> both 0xDEADBEEF. index=5 -> number=0xDEADBEEF.
- Forwarding: in one cycle regwrite=1, writeaddr=9, writedata=0x12345678, rs=9 -> rsdata=0x12345678 in the same cycle. number with index=9 shows the old value 0 until the edge.
- Zero register: write 0xFFFFFFFF to r0, rs=0 -> rsdata=0 in both the same and the next cycle. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- clear_req mid-use:
  - Fill r1..r31 with the value i, pulse clear_req.
  - busy is 1 for 32 cycles; writes issued during busy are dropped.
  - Afterwards all registers read 0.
  - A second clear_req at cycle 10 of the clear does not extend busy.
- Parametrisation: DATA_W=16, ADDR_W=4, DEPTH=12.
  - Clear lasts 12 cycles.
  - A write to address 13 is dropped; rs=13 reads 0.
  - A write of 0xBEEF to r11 reads back 0xBEEF.
